pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline.
- Drives the enable and synchronous-flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the PC write enable.
- Resolves three hazards: load-use data hazards, taken branches/jumps resolved in MEM, and multi-cycle data-memory accesses using a req/ready handshake with a timeout.

---
 rtl/pipe_hazard_ctrl_if.sv | 53 +++++
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard-controller bundle between the pipeline and the stall/flush sequencer
//
// Purpose: carries the hazard sources observed in ID/EX/MEM and the
// enable/flush controls returned to the pipeline registers and PC.
// Modports:
//   master - the hazard controller (reads hazard sources, drives controls)
//   slave  - the pipeline side (drives hazard sources, reads controls)
// Signals:
//   Rs1_addr_ID, Rs2_addr_ID, Rs1_used_ID, Rs2_used_ID   ID-stage operand usage
//   Rd_addr_EX, RegWrite_EX, MemtoReg_EX                 EX-stage destination / load marker
//   taken_Mem, dmem_req_Mem, dmem_ready                  MEM-stage branch and memory handshake
//   PC_en, en_IFID, en_IDEX, en_EXMem, en_MemWB          register enables
//   flush_IFID, flush_IDEX, flush_EXMem                  synchronous bubble inserts
//   err_timeout                                          sticky memory-timeout flag

interface pipe_hazard_ctrl_if;
  logic [4:0] Rs1_addr_ID;
  logic [4:0] Rs2_addr_ID;
  logic       Rs1_used_ID;
  logic       Rs2_used_ID;
  logic [4:0] Rd_addr_EX;
  logic       RegWrite_EX;
  logic [1:0] MemtoReg_EX;
  logic       taken_Mem;
  logic       dmem_req_Mem;
  logic       dmem_ready;

  logic       PC_en;
  logic       en_IFID;
  logic       en_IDEX;
  logic       en_EXMem;
  logic       en_MemWB;
  logic       flush_IFID;
  logic       flush_IDEX;
  logic       flush_EXMem;
  logic       err_timeout;

  modport master (
    input  Rs1_addr_ID, Rs2_addr_ID, Rs1_used_ID, Rs2_used_ID,
    input  Rd_addr_EX, RegWrite_EX, MemtoReg_EX,
    input  taken_Mem, dmem_req_Mem, dmem_ready,
    output PC_en, en_IFID, en_IDEX, en_EXMem, en_MemWB,
    output flush_IFID, flush_IDEX, flush_EXMem, err_timeout
  );

  modport slave (
    output Rs1_addr_ID, Rs2_addr_ID, Rs1_used_ID, Rs2_used_ID,
    output Rd_addr_EX, RegWrite_EX, MemtoReg_EX,
    output taken_Mem, dmem_req_Mem, dmem_ready,
    input  PC_en, en_IFID, en_IDEX, en_EXMem, en_MemWB,
    input  flush_IFID, flush_IDEX, flush_EXMem, err_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
//
// Purpose: resolves load-use hazards (one bubble), taken branches resolved in
// MEM (flush IF/ID, ID/EX, EX/MEM) and multi-cycle data-memory accesses (full
// freeze with a timeout that forces release and sets a sticky error flag).
// Ports:
//   clk_HC  - pipeline clock, rising edge
//   rst_HC  - asynchronous active-low reset
//   hc      - pipe_hazard_ctrl_if.master (hazard sources in, controls out)
//   stall_cnt, flush_cnt, memwait_cnt - saturating performance counters,
//             present only when HC_PERF_CNT_EN is defined
// Parameters:
//   MEM_TIMEOUT - max cycles in MEM_WAIT before forced release (2..255)
//   CNT_W       - performance counter width
// Optional feature macro: HC_PERF_CNT_EN

module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk_HC,
  input  logic               rst_HC,
  pipe_hazard_ctrl_if.master hc
`ifdef HC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic [CNT_W-1:0]   memwait_cnt
`endif
);

  if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_bad_param
    $error("pipe_hazard_ctrl: illegal MEM_TIMEOUT or CNT_W");
  end

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  typedef enum logic {ST_RUN, ST_MEM_WAIT} state_t;

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       err_q, err_nxt;

  logic lu, mp;
  logic freeze, lu_bubble, do_flush;

  assign lu = hc.RegWrite_EX && (hc.MemtoReg_EX == 2'b01) && (hc.Rd_addr_EX != 5'd0) &&
              ((hc.Rs1_used_ID && (hc.Rs1_addr_ID == hc.Rd_addr_EX)) ||
               (hc.Rs2_used_ID && (hc.Rs2_addr_ID == hc.Rd_addr_EX)));
  assign mp = hc.dmem_req_Mem && !hc.dmem_ready;

  always_ff @(posedge clk_HC or negedge rst_HC) begin
    if (!rst_HC) begin
      state    <= ST_RUN;
      wait_cnt <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      err_q    <= err_nxt;
    end
  end

  // Any non-freeze cycle (RUN without MP, or a MEM_WAIT release) resolves
  // branch flush ahead of the load-use bubble; EX/MEM held its contents while
  // frozen, so taken_Mem is still meaningful on the release cycle.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    err_nxt      = err_q;
    freeze       = 1'b0;
    case (state)
      ST_RUN: begin
        if (mp) begin
          freeze       = 1'b1;
          wait_cnt_nxt = 8'd1;
          state_nxt    = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (mp && (wait_cnt < TIMEOUT)) begin
          freeze       = 1'b1;
          wait_cnt_nxt = wait_cnt + 8'd1;
        end else begin
          // A dropped request counts as ready and is not a timeout.
          if (mp) err_nxt = 1'b1;
          wait_cnt_nxt = 8'd0;
          state_nxt    = ST_RUN;
        end
      end
      default: begin
        state_nxt    = ST_RUN;
        wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  assign do_flush  = !freeze && hc.taken_Mem;
  assign lu_bubble = !freeze && !hc.taken_Mem && lu;

  assign hc.PC_en       = !freeze && !lu_bubble;
  assign hc.en_IFID     = !freeze && !lu_bubble;
  assign hc.en_IDEX     = !freeze;
  assign hc.en_EXMem    = !freeze;
  assign hc.en_MemWB    = !freeze;
  assign hc.flush_IFID  = do_flush;
  assign hc.flush_IDEX  = do_flush || lu_bubble;
  assign hc.flush_EXMem = do_flush;
  assign hc.err_timeout = err_q;

`ifdef HC_PERF_CNT_EN
  always_ff @(posedge clk_HC or negedge rst_HC) begin
    if (!rst_HC) begin
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      memwait_cnt <= '0;
    end else begin
      if (lu_bubble && (stall_cnt != '1))  stall_cnt   <= stall_cnt + 1'b1;
      if (do_flush && (flush_cnt != '1))   flush_cnt   <= flush_cnt + 1'b1;
      if (freeze && (memwait_cnt != '1))   memwait_cnt <= memwait_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl

module tb_pipe_hazard_ctrl;

  logic clk_HC = 1'b0;
  logic rst_HC = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_HC = ~clk_HC;

  pipe_hazard_ctrl_if hc ();

`ifdef HC_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, memwait_cnt;
`endif

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk_HC (clk_HC),
    .rst_HC (rst_HC),
    .hc     (hc)
`ifdef HC_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
    .memwait_cnt (memwait_cnt)
`endif
  );

  // {PC_en, en_IFID, en_IDEX, en_EXMem, en_MemWB, flush_IFID, flush_IDEX, flush_EXMem}
  localparam logic [7:0] NORM = 8'b11111_000;
  localparam logic [7:0] FRZ  = 8'b00000_000;
  localparam logic [7:0] FLS  = 8'b11111_111;
  localparam logic [7:0] LUB  = 8'b00111_010;

  task automatic tick();
    @(posedge clk_HC);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {hc.PC_en, hc.en_IFID, hc.en_IDEX, hc.en_EXMem, hc.en_MemWB,
           hc.flush_IFID, hc.flush_IDEX, hc.flush_EXMem};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_err(input string tag, input logic exp);
    checks++;
    assert (hc.err_timeout === exp) else begin
      errors++;
      $error("FAIL %s: observed err_timeout=%b expected %b", tag, hc.err_timeout, exp);
    end
  endtask

  task automatic clear_inputs();
    hc.Rs1_addr_ID  = 5'd0;
    hc.Rs2_addr_ID  = 5'd0;
    hc.Rs1_used_ID  = 1'b0;
    hc.Rs2_used_ID  = 1'b0;
    hc.Rd_addr_EX   = 5'd0;
    hc.RegWrite_EX  = 1'b0;
    hc.MemtoReg_EX  = 2'b00;
    hc.taken_Mem    = 1'b0;
    hc.dmem_req_Mem = 1'b0;
    hc.dmem_ready   = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2);
    hc.Rd_addr_EX  = rd;
    hc.RegWrite_EX = 1'b1;
    hc.MemtoReg_EX = 2'b01;
    hc.Rs1_addr_ID = rs1;
    hc.Rs1_used_ID = u1;
    hc.Rs2_addr_ID = rs2;
    hc.Rs2_used_ID = u2;
  endtask

  initial begin
    clear_inputs();
    #12;
    chk("reset_outputs", NORM);
    chk_err("reset_err", 1'b0);
    rst_HC = 1'b1;
    tick();

    chk("idle", NORM);
    tick();

    // Load-use through rs2, then the load moves to MEM and the hazard clears
    set_load_use(5'd5, 5'd1, 1'b1, 5'd5, 1'b1);
    #2 chk("lu_rs2", LUB);
    tick();
    clear_inputs();
    #2 chk("lu_after", NORM);
    tick();

    set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    #2 chk("lu_rd0", NORM);
    tick();

    set_load_use(5'd7, 5'd7, 1'b1, 5'd3, 1'b0);
    #2 chk("lu_rs1", LUB);
    tick();
    hc.Rs1_used_ID = 1'b0;
    #2 chk("lu_rs1_unused", NORM);
    tick();
    hc.Rs1_used_ID = 1'b1;
    hc.MemtoReg_EX = 2'b00;
    #2 chk("lu_not_load", NORM);
    tick();

    // Branch beats load-use
    set_load_use(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    hc.taken_Mem = 1'b1;
    #2 chk("taken_over_lu", FLS);
    tick();
    clear_inputs();

    // Memory wait: three freeze cycles, release on ready
    hc.dmem_req_Mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2 chk($sformatf("memwait_frz%0d", i), FRZ);
      tick();
    end
    hc.dmem_ready = 1'b1;
    #2 chk("memwait_release", NORM);
    tick();
    clear_inputs();
    #2 chk("memwait_back_run", NORM);
    chk_err("memwait_no_err", 1'b0);
    tick();

    // Wait plus branch held: release cycle flushes
    hc.dmem_req_Mem = 1'b1;
    hc.taken_Mem    = 1'b1;
    #2 chk("wait_br_frz0", FRZ);
    tick();
    #2 chk("wait_br_frz1", FRZ);
    tick();
    hc.dmem_ready = 1'b1;
    #2 chk("wait_br_release", FLS);
    tick();
    clear_inputs();

    // Wait with load-use pending: bubble appears on the release cycle
    hc.dmem_req_Mem = 1'b1;
    set_load_use(5'd12, 5'd0, 1'b0, 5'd12, 1'b1);
    #2 chk("wait_lu_frz", FRZ);
    tick();
    hc.dmem_ready = 1'b1;
    #2 chk("wait_lu_release", LUB);
    tick();
    clear_inputs();

    // Timeout: four freeze cycles then forced release and sticky error
    hc.dmem_req_Mem = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2 chk($sformatf("timeout_frz%0d", i), FRZ);
      tick();
    end
    #2 chk("timeout_release", NORM);
    chk_err("timeout_err_pre", 1'b0);
    tick();
    #2 chk("timeout_rerequest", FRZ);
    chk_err("timeout_err_set", 1'b1);
    tick();
    hc.dmem_req_Mem = 1'b0;
    #2 chk("req_drop_release", NORM);
    tick();
    #2 chk_err("timeout_err_held", 1'b1);
    tick();

    // Reset during MEM_WAIT
    hc.dmem_req_Mem = 1'b1;
    #2 chk("rst_wait_frz0", FRZ);
    tick();
    #2 chk("rst_wait_frz1", FRZ);
    tick();
    rst_HC = 1'b0;
    #2 chk_err("rst_mid_err", 1'b0);
    chk("rst_mid_outputs", FRZ);
`ifdef HC_PERF_CNT_EN
    checks++;
    assert ({stall_cnt, flush_cnt, memwait_cnt} === 96'd0) else begin
      errors++;
      $error("FAIL rst_counters: observed %0d/%0d/%0d expected 0/0/0", stall_cnt, flush_cnt, memwait_cnt);
    end
`endif
    #2 rst_HC = 1'b1;
    // From RUN the timeout sequence restarts in full
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) begin
        #2 chk($sformatf("rst_restart_frz%0d", i + 1), FRZ);
      end else begin
        #2 chk("rst_restart_release", NORM);
      end
    end
    tick();
    clear_inputs();
    #2 chk("final_idle", NORM);
    chk_err("final_err_after_timeout", 1'b1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
